// File: rtl/dac_seq_pkg.sv
// Shared types and defaults for the DAC level sequencer: FSM states and the
// (level, dwell) table entry.
package dac_seq_pkg;

  localparam int DAC_W_DEF   = 16;
  localparam int DEPTH_DEF   = 8;
  localparam int DWELL_W_DEF = 32;
  localparam int LOOP_W_DEF  = 16;
  localparam logic [DAC_W_DEF-1:0] IDLE_CODE_DEF = 16'h03FF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DAC_W_DEF-1:0]   level;
    logic [DWELL_W_DEF-1:0] dwell;
  } entry_t;

endpackage

// File: rtl/dac_seq_table.sv
// Segment table: DEPTH registered (level, dwell) pairs, synchronous write,
// combinational read, cleared to {IDLE_CODE, 1} on reset.
module dac_seq_table #(
  parameter int DEPTH   = 8,
  parameter int DAC_W   = 16,
  parameter int DWELL_W = 32,
  parameter logic [DAC_W-1:0] IDLE_CODE = 16'h03FF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [DAC_W-1:0]   wlevel,
  input  logic [DWELL_W-1:0] wdwell,
  input  logic [AW-1:0]      raddr,
  output logic [DAC_W-1:0]   rlevel,
  output logic [DWELL_W-1:0] rdwell
);

  logic [DAC_W-1:0]   level_q [DEPTH];
  logic [DWELL_W-1:0] dwell_q [DEPTH];
  logic               addr_ok;

  // With a power-of-two depth every address is in range.
  generate
    if ((1 << AW) == DEPTH) begin : g_pow2
      assign addr_ok = 1'b1;
    end else begin : g_npow2
      assign addr_ok = (int'(waddr) < DEPTH);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        level_q[i] <= IDLE_CODE;
        dwell_q[i] <= DWELL_W'(1);
      end
    end else if (we && addr_ok) begin
      level_q[waddr] <= wlevel;
      dwell_q[waddr] <= wdwell;
    end
  end

  assign rlevel = level_q[raddr];
  assign rdwell = dwell_q[raddr];

endmodule

// File: rtl/dac_level_sequencer.sv
// Steps a DAC code through a programmable table of (level, dwell) segments for
// N loops or forever, then parks at IDLE_CODE.
module dac_level_sequencer
  import dac_seq_pkg::*;
#(
  parameter int DAC_W   = DAC_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int LOOP_W  = LOOP_W_DEF,
  parameter logic [DAC_W-1:0] IDLE_CODE = DAC_W'(16'h03FF),
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [AW-1:0]      cfg_addr,
  input  logic [DAC_W-1:0]   cfg_level,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [LW-1:0]      cfg_len,
  input  logic [LOOP_W-1:0]  cfg_loops,
  input  logic               start,
  input  logic               stop,
  output logic [DAC_W-1:0]   dac_code,
  output logic               dac_upd,
  output logic               busy,
  output logic [AW-1:0]      seg_idx,
  output logic               done,
  output logic               cfg_err,
  output state_t             state_dbg
);

  state_t             state_q, state_n;
  logic [AW-1:0]      idx_q, idx_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic [LOOP_W-1:0]  loop_q, loop_n;
  logic [LW-1:0]      len_q, len_n;
  logic               forever_q, forever_n;
  logic [DAC_W-1:0]   code_q, code_n;
  logic               upd_n, done_n, err_n;

  logic [AW-1:0]      rd_addr;
  logic [DAC_W-1:0]   rd_level;
  logic [DWELL_W-1:0] rd_dwell, load_dwell;
  logic               len_ok, last_seg;

  dac_seq_table #(
    .DEPTH(DEPTH), .DAC_W(DAC_W), .DWELL_W(DWELL_W), .IDLE_CODE(IDLE_CODE)
  ) u_table (
    .clk(clk), .rst(rst),
    .we(cfg_we), .waddr(cfg_addr), .wlevel(cfg_level), .wdwell(cfg_dwell),
    .raddr(rd_addr), .rlevel(rd_level), .rdwell(rd_dwell)
  );

  assign len_ok     = (cfg_len != '0) && (int'(cfg_len) <= DEPTH);
  assign last_seg   = ({1'b0, idx_q} == len_q - LW'(1));
  // The table is always addressed at the entry that the next load would take.
  assign rd_addr    = (state_q == RUN && !last_seg) ? idx_q + AW'(1) : '0;
  // Counter holds remaining cycles after the current one; dwell 0 acts as 1.
  assign load_dwell = (rd_dwell == '0) ? '0 : rd_dwell - DWELL_W'(1);

  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    dwell_n   = dwell_q;
    loop_n    = loop_q;
    len_n     = len_q;
    forever_n = forever_q;
    code_n    = code_q;
    upd_n     = 1'b0;
    done_n    = 1'b0;
    err_n     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          if (len_ok) begin
            len_n     = cfg_len;
            forever_n = (cfg_loops == '0);
            loop_n    = cfg_loops;
            idx_n     = '0;
            code_n    = rd_level;
            dwell_n   = load_dwell;
            upd_n     = 1'b1;
            state_n   = RUN;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (stop) begin
          code_n  = IDLE_CODE;
          upd_n   = 1'b1;
          idx_n   = '0;
          state_n = IDLE;
        end else if (dwell_q != '0) begin
          dwell_n = dwell_q - DWELL_W'(1);
        end else if (!last_seg) begin
          idx_n   = idx_q + AW'(1);
          code_n  = rd_level;
          dwell_n = load_dwell;
          upd_n   = 1'b1;
        end else if (forever_q || loop_q > LOOP_W'(1)) begin
          if (!forever_q) loop_n = loop_q - LOOP_W'(1);
          idx_n   = '0;
          code_n  = rd_level;
          dwell_n = load_dwell;
          upd_n   = 1'b1;
        end else begin
          code_n  = IDLE_CODE;
          upd_n   = 1'b1;
          done_n  = 1'b1;
          idx_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      dwell_q   <= '0;
      loop_q    <= '0;
      len_q     <= '0;
      forever_q <= 1'b0;
      code_q    <= IDLE_CODE;
      dac_upd   <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      dwell_q   <= dwell_n;
      loop_q    <= loop_n;
      len_q     <= len_n;
      forever_q <= forever_n;
      code_q    <= code_n;
      dac_upd   <= upd_n;
      done      <= done_n;
      cfg_err   <= err_n;
    end
  end

  assign dac_code  = code_q;
  assign busy      = (state_q == RUN);
  assign seg_idx   = idx_q;
  assign state_dbg = state_q;

endmodule
